// File: rtl/traffic_phase_controller_if.sv
// Interval-timer handshake between the phase controller (master) and the timer (slave).
interface traffic_phase_controller_if;
  logic       start_timer;
  logic [3:0] value;
  logic       expired;
  logic       one_hz_enable;

  modport master (output start_timer, output value, input expired, input one_hz_enable);
  modport slave  (input start_timer, input value, output expired, output one_hz_enable);
endinterface

// File: rtl/traffic_phase_controller.sv
// Traffic-light phase sequencer; arms the interval timer on every state entry.
// state       | meaning
// ALL_RED     | clearance, every lamp red
// MAIN_GREEN  | base main-road green
// MAIN_EXT    | main green extended while no demand is waiting
// MAIN_YELLOW | main-road yellow
// SIDE_GREEN  | side-road green
// SIDE_YELLOW | side-road yellow
// WALK        | steady pedestrian walk
// WALK_BLINK  | flashing walk, toggles on the 1 Hz tick
module traffic_phase_controller #(
  parameter logic [3:0] T_ALLRED = 4'd1,
  parameter logic [3:0] T_MAIN   = 4'd6,
  parameter logic [3:0] T_EXT    = 4'd2,
  parameter logic [3:0] T_SIDE   = 4'd4,
  parameter logic [3:0] T_YEL    = 4'd2,
  parameter logic [3:0] T_WALK   = 4'd4,
  parameter logic [3:0] T_BLINK  = 4'd3
) (
  input  logic                              clock,
  input  logic                              reset,
  traffic_phase_controller_if.master        tmr,
  input  logic                              side_sensor,
  input  logic                              walk_request,
  output logic [2:0]                        main_light,
  output logic [2:0]                        side_light,
  output logic                              walk_lamp,
  output logic [2:0]                        state_code
);

  typedef enum logic [2:0] {
    ALL_RED     = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_EXT    = 3'd2,
    MAIN_YELLOW = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    WALK        = 3'd6,
    WALK_BLINK  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  state_t     state, state_nxt;
  logic       arm, arm_nxt;
  logic       pend, pend_nxt;
  logic       start_nxt;
  logic       enter;
  logic       walk_nxt;
  logic [3:0] value_nxt;
  logic [2:0] main_nxt, side_nxt;

  // The timer cannot count a zero-length interval, so zero is promoted to one.
  function automatic logic [3:0] nz(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  function automatic logic [3:0] interval_of(input state_t s);
    case (s)
      MAIN_GREEN:               return nz(T_MAIN);
      MAIN_EXT:                 return nz(T_EXT);
      MAIN_YELLOW, SIDE_YELLOW: return nz(T_YEL);
      SIDE_GREEN:               return nz(T_SIDE);
      WALK:                     return nz(T_WALK);
      WALK_BLINK:               return nz(T_BLINK);
      default:                  return nz(T_ALLRED);
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    arm_nxt   = arm;
    pend_nxt  = pend;
    start_nxt = 1'b0;
    enter     = 1'b0;
    value_nxt = tmr.value;
    walk_nxt  = walk_lamp;

    if (walk_request && state != WALK && state != WALK_BLINK)
      pend_nxt = 1'b1;

    // expired still reflects the previous interval during the start pulse
    if (arm) begin
      arm_nxt   = 1'b0;
      start_nxt = 1'b1;
      value_nxt = nz(T_ALLRED);
    end else if (!tmr.start_timer && tmr.expired) begin
      enter = 1'b1;
      case (state)
        ALL_RED:              state_nxt = MAIN_GREEN;
        MAIN_GREEN, MAIN_EXT: state_nxt = (side_sensor || pend) ? MAIN_YELLOW : MAIN_EXT;
        MAIN_YELLOW:          state_nxt = pend ? WALK : SIDE_GREEN;
        SIDE_GREEN:           state_nxt = SIDE_YELLOW;
        SIDE_YELLOW:          state_nxt = ALL_RED;
        WALK:                 state_nxt = WALK_BLINK;
        WALK_BLINK:           state_nxt = ALL_RED;
        default:              state_nxt = ALL_RED;
      endcase
    end

    if (enter) begin
      start_nxt = 1'b1;
      value_nxt = interval_of(state_nxt);
      walk_nxt  = (state_nxt == WALK) || (state_nxt == WALK_BLINK);
      if (state_nxt == WALK)
        pend_nxt = 1'b0;
    end else if (state == WALK_BLINK && tmr.one_hz_enable) begin
      walk_nxt = ~walk_lamp;
    end

    case (state_nxt)
      MAIN_GREEN, MAIN_EXT: main_nxt = LAMP_GRN;
      MAIN_YELLOW:          main_nxt = LAMP_YEL;
      default:              main_nxt = LAMP_RED;
    endcase

    case (state_nxt)
      SIDE_GREEN:  side_nxt = LAMP_GRN;
      SIDE_YELLOW: side_nxt = LAMP_YEL;
      default:     side_nxt = LAMP_RED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ALL_RED;
      arm             <= 1'b1;
      pend            <= 1'b0;
      tmr.start_timer <= 1'b0;
      tmr.value       <= nz(T_ALLRED);
      main_light      <= LAMP_RED;
      side_light      <= LAMP_RED;
      walk_lamp       <= 1'b0;
    end else begin
      state           <= state_nxt;
      arm             <= arm_nxt;
      pend            <= pend_nxt;
      tmr.start_timer <= start_nxt;
      tmr.value       <= value_nxt;
      main_light      <= main_nxt;
      side_light      <= side_nxt;
      walk_lamp       <= walk_nxt;
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: a phase-level reference model predicts every timer arm and the walk lamp.
module tb_traffic_phase_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       side_sensor;
  logic       walk_request;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_lamp;
  logic [2:0] state_code;

  traffic_phase_controller_if tif ();

  traffic_phase_controller dut (
    .clock        (clock),
    .reset        (reset),
    .tmr          (tif),
    .side_sensor  (side_sensor),
    .walk_request (walk_request),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk_lamp    (walk_lamp),
    .state_code   (state_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         ph;
    int         val;
    logic [2:0] ml;
    logic [2:0] sl;
  } exp_t;

  exp_t exp_q[$];
  bit   wl_q[$];
  int   total = 0;
  int   bad   = 0;

  // phase codes: 0 all-red, 1 main green, 2 main ext, 3 main yellow,
  // 4 side green, 5 side yellow, 6 walk, 7 walk blink
  int   interval[8] = '{1, 6, 2, 2, 4, 2, 4, 3};

  int   m_ph;
  bit   m_arm, m_pulse, m_pend, m_wl;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] main_of(input int ph);
    if (ph == 1 || ph == 2) return 3'b001;
    if (ph == 3)            return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] side_of(input int ph);
    if (ph == 4) return 3'b001;
    if (ph == 5) return 3'b010;
    return 3'b100;
  endfunction

  function automatic int succ(input int ph, input bit ss, input bit pend);
    case (ph)
      0:       return 1;
      1, 2:    return (ss || pend) ? 3 : 2;
      3:       return pend ? 6 : 4;
      4:       return 5;
      5:       return 0;
      6:       return 7;
      default: return 0;
    endcase
  endfunction

  // Reference model: advances on qualified expiry, queues each expected timer arm.
  always @(posedge clock) begin
    if (!reset) begin
      m_ph = 0; m_arm = 1; m_pulse = 0; m_pend = 0; m_wl = 0;
      exp_q.delete();
      wl_q.delete();
    end else begin
      bit fire;
      int nph;
      exp_t ex;
      fire = !m_arm && !m_pulse && tif.expired;
      nph  = fire ? succ(m_ph, side_sensor, m_pend) : m_ph;
      if (walk_request && m_ph < 6) m_pend = 1;
      if (fire && nph == 6)         m_pend = 0;
      if (fire)                               m_wl = (nph >= 6);
      else if (m_ph == 7 && tif.one_hz_enable) m_wl = !m_wl;
      m_pulse = m_arm || fire;
      m_arm   = 0;
      m_ph    = nph;
      if (m_pulse) begin
        ex.ph = nph; ex.val = interval[nph]; ex.ml = main_of(nph); ex.sl = side_of(nph);
        exp_q.push_back(ex);
      end
      wl_q.push_back(m_wl);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      exp_t ex;
      chk("main_onehot", int'($countones(main_light)), 1);
      chk("side_onehot", int'($countones(side_light)), 1);
      if (tif.start_timer) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          ex = exp_q.pop_front();
          chk("entry_state", state_code, ex.ph);
          chk("entry_value", tif.value, ex.val);
          chk("entry_main", main_light, ex.ml);
          chk("entry_side", side_light, ex.sl);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_start", 0, 1);
        void'(exp_q.pop_front());
      end
      if (wl_q.size() == 0) chk("walk_underflow", 0, 1);
      else                  chk("walk_lamp", walk_lamp, wl_q.pop_front());
    end
  end

  task automatic drive(input bit e, input bit ss, input bit wr, input bit oh);
    tif.expired       = e;
    side_sensor       = ss;
    walk_request      = wr;
    tif.one_hz_enable = oh;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_start"}, tif.start_timer, 0);
    chk({tag, "_value"}, tif.value, 1);
    chk({tag, "_main"},  main_light, 3'b100);
    chk({tag, "_side"},  side_light, 3'b100);
    chk({tag, "_walk"},  walk_lamp, 0);
    chk({tag, "_state"}, state_code, 0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_expired(input bit ss, input int gap);
    drive(1, ss, 0, 0);
    repeat (gap) drive(0, ss, 0, 0);
  endtask

  // Arm from reset, then main green and repeated extensions.
  task automatic scenario_main();
    repeat (3) drive(0, 0, 0, 0);
    pulse_expired(0, 3);
    repeat (3) pulse_expired(0, 2);
  endtask

  initial begin
    bit reached;
    reset = 1'b0;
    tif.expired = 0; tif.one_hz_enable = 0; side_sensor = 0; walk_request = 0;
    repeat (3) @(posedge clock);
    #1 reset_checks("init");
    release_reset();
    scenario_main();

    // side-road service
    repeat (5) pulse_expired(1, 2);

    // pedestrian cycle from main green, with three 1 Hz ticks in blink
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    repeat (2) pulse_expired(1, 2);
    pulse_expired(0, 2);
    repeat (3) begin
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
    end
    pulse_expired(0, 3);

    // expired held high across many entries
    repeat (20) drive(1, 0, 0, 0);
    repeat (12) drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);

    // reach side green, leave a pending walk, then reset mid-interval
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      drive((i % 3) == 0, 1, 0, 0);
      if (state_code == 3'd4) reached = 1;
    end
    chk("reach_side_green", reached, 1);
    drive(0, 1, 1, 0);
    #2 reset = 1'b0;
    #1 reset_checks("mid");
    repeat (2) @(posedge clock);
    release_reset();
    scenario_main();

    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) == 0, ($urandom % 3) == 0,
            ($urandom % 16) == 0, ($urandom % 3) == 0);

    repeat (3) drive(0, 0, 0, 0);
    @(negedge clock);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Initiator side of the interval-timer handshake. A traffic-light phase FSM drives the timer's start_timer/value inputs and consumes its expired and one_hz_enable outputs. It sequences main-road and side-road lamps and a pedestrian walk lamp, and sits between the sensor/button inputs and the lamp drivers.

Parameters:
T_ALLRED, 4'd1, all-red clearance interval (timer units)
T_MAIN, 4'd6, base main-green interval
T_EXT, 4'd2, main-green extension when no demand
T_SIDE, 4'd4, side-green interval
T_YEL, 4'd2, yellow interval (both roads)
T_WALK, 4'd4, steady walk interval
T_BLINK, 4'd3, flashing walk interval

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
expired  in  1  timer interval finished (level)
one_hz_enable  in  1  timer 1 Hz tick pulse, one cycle wide
side_sensor  in  1  vehicle waiting on side road (level, synchronous)
walk_request  in  1  pedestrian button (synchronous, any width)
start_timer  out  1  one-cycle pulse that loads the timer
value  out  4  interval length presented to the timer
main_light  out  3  {red,yellow,green} for main road
side_light  out  3  {red,yellow,green} for side road
walk_lamp  out  1  pedestrian walk lamp
state_code  out  3  current state encoding, for debug

Behaviour:
- States and codes: ALL_RED=0, MAIN_GREEN=1, MAIN_EXT=2, MAIN_YELLOW=3, SIDE_GREEN=4, SIDE_YELLOW=5, WALK=6, WALK_BLINK=7.
- Reset asserted (reset==0) sets, asynchronously: state=ALL_RED, start_timer=0, value=T_ALLRED, main_light=side_light=3'b100, walk_lamp=0, walk_pending=0, and the arm flag set.
- First clock edge after reset release: start_timer=1, value=T_ALLRED.
- Every state entry, including re-entry of MAIN_EXT, asserts start_timer for exactly one cycle. The entry pulse is registered on the same edge as the state change.
- value is loaded on the same edge as the pulse and held until the next state entry.
- While start_timer==1, expired is ignored, because it still reflects the previous interval. A transition occurs only on a cycle with start_timer==0 and expired==1.
- Transitions on qualified expired:
  - ALL_RED -> MAIN_GREEN (T_MAIN).
  - MAIN_GREEN or MAIN_EXT -> MAIN_YELLOW (T_YEL) if side_sensor or walk_pending; otherwise -> MAIN_EXT (T_EXT).
  - MAIN_YELLOW -> WALK (T_WALK) if walk_pending, else -> SIDE_GREEN (T_SIDE). walk_pending has priority over side_sensor.
  - SIDE_GREEN -> SIDE_YELLOW (T_YEL) -> ALL_RED.
  - WALK -> WALK_BLINK (T_BLINK) -> ALL_RED.
- Lamps:
  - main_light is green in MAIN_GREEN/MAIN_EXT, yellow in MAIN_YELLOW, red otherwise.
  - side_light is green in SIDE_GREEN, yellow in SIDE_YELLOW, red otherwise.
  - Exactly one bit of each lamp vector is set at all times.
  - Lamps are registered and change on the same edge as the state.
- walk_pending:
  - Set on any cycle with walk_request==1 outside WALK/WALK_BLINK.
  - Cleared on the edge entering WALK.
  - Requests during WALK/WALK_BLINK are dropped.
  - A request coincident with the MAIN_YELLOW->decision edge does not count for that decision; it is serviced in the next cycle round.
- walk_lamp:
  - 1 throughout WALK.
  - Entering WALK_BLINK: walk_lamp=1, then it toggles on each one_hz_enable pulse while in WALK_BLINK.
  - 0 in all other states.
- Any parameter value of 0 is driven as 4'd1; value is never 0.
- If reset is asserted mid-interval, outputs return to their reset values immediately, with no start pulse until release.
- Unused state codes cannot occur. A defensive default returns to ALL_RED with an entry pulse.

Test Plan:
- Reset release, expired held 0 -> start_timer high exactly one cycle with value=1; main/side=100/100; state_code=0.
- Expired pulse after ALL_RED, no demand -> MAIN_GREEN with value=6. Next expired -> MAIN_EXT, value=2, start pulse. Repeat expired -> MAIN_EXT re-armed each time, main stays green.
- side_sensor=1 in MAIN_GREEN, expired -> MAIN_YELLOW (value=2, main=010), then SIDE_GREEN (value=4, side=001, main=100), SIDE_YELLOW, ALL_RED.
- walk_request 1-cycle pulse in MAIN_GREEN with side_sensor=1 -> after MAIN_YELLOW enters WALK (walk_lamp=1, value=4). Then WALK_BLINK (value=3): 3 one_hz_enable pulses give walk_lamp 1->0->1->0. Then ALL_RED with walk_lamp=0.
- expired held 1 continuously through a transition -> only one transition per state; no state skipped during the start pulse cycle.
- reset asserted mid SIDE_GREEN -> all outputs at reset values asynchronously; walk_pending cleared; restart identical to the first scenario.
